// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : EX/MEM register, data-memory req/ack access, MEM/WB register   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_stage #(
    parameter logic [4:0] VEC_LOAD_MISALIGN  = 5'd4,
    parameter logic [4:0] VEC_STORE_MISALIGN = 5'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] rt_in,
    input  logic [7:0]  control_in,
    input  logic [4:0]  regdst_in,
    input  logic [4:0]  vector_in,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall,
    output logic [31:0] ex_mem_data,
    output logic [4:0]  ex_mem_regdst,
    output logic        ex_mem_regwrite,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_regdst,
    output logic        wb_regwrite,
    output logic [4:0]  wb_vector,
    output logic [31:0] wb_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [31:0] alu_q, alu_d, rt_q, rt_d, pc_q, pc_d;
    logic [7:1]  ctrl_q, ctrl_d;
    logic [4:0]  rd_q, rd_d, vec_q, vec_d;
    state_t      state_q, state_d;
    logic [31:0] ldbuf_q, ldbuf_d;
    logic [31:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
    logic [4:0]  wb_regdst_q, wb_regdst_d, wb_vector_q, wb_vector_d;
    logic        wb_regwrite_q, wb_regwrite_d;

    logic        w_mem_read, w_mem_write, w_misalign, w_mem_op, w_eff_rw, w_req;
    logic [1:0]  w_size;
    logic [4:0]  w_eff_vec;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_unused;

    assign w_unused = control_in[0];

    // Exception resolution: an upstream vector outranks a local misalignment.
    always_comb begin
        w_mem_read  = ctrl_q[7];
        w_mem_write = ctrl_q[6];
        w_size      = ctrl_q[5:4];
        case (w_size)
            2'b01:   w_misalign = alu_q[0];
            2'b10:   w_misalign = 1'b0;
            default: w_misalign = |alu_q[1:0];
        endcase
        w_eff_vec = 5'd0;
        if (vec_q != 5'd0)
            w_eff_vec = vec_q;
        else if (w_misalign && w_mem_read)
            w_eff_vec = VEC_LOAD_MISALIGN;
        else if (w_misalign && w_mem_write)
            w_eff_vec = VEC_STORE_MISALIGN;
        w_mem_op = (w_mem_read | w_mem_write) && (w_eff_vec == 5'd0);
        w_eff_rw = ctrl_q[2] && (w_eff_vec == 5'd0);
        stall    = w_mem_op && (state_q != S_DONE);
    end

    always_comb begin
        w_req      = (state_q == S_REQ);
        dmem_req   = w_req;
        dmem_we    = w_req & w_mem_write;
        dmem_addr  = w_req ? {alu_q[31:2], 2'b00} : 32'd0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'd0;
        if (w_req) begin
            case (w_size)
                2'b01: begin
                    dmem_be    = alu_q[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{rt_q[15:0]}};
                end
                2'b10: begin
                    dmem_be    = 4'b0001 << alu_q[1:0];
                    dmem_wdata = {4{rt_q[7:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = rt_q;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = ldbuf_q[{alu_q[1:0], 3'b000} +: 8];
        w_half = alu_q[1] ? ldbuf_q[31:16] : ldbuf_q[15:0];
        case (w_size)
            2'b01:   w_load = ctrl_q[1] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            2'b10:   w_load = ctrl_q[1] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            default: w_load = ldbuf_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ldbuf_d = ldbuf_q;
        case (state_q)
            S_IDLE: if (w_mem_op) state_d = S_REQ;
            S_REQ: begin
                if (dmem_ack) begin
                    ldbuf_d = dmem_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // EX/MEM holds under stall; a flush only matters when it would advance.
    always_comb begin
        alu_d  = alu_q;
        rt_d   = rt_q;
        pc_d   = pc_q;
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        vec_d  = vec_q;
        if (!stall) begin
            if (flush) begin
                alu_d  = 32'd0;
                rt_d   = 32'd0;
                pc_d   = 32'd0;
                ctrl_d = 7'd0;
                rd_d   = 5'd0;
                vec_d  = 5'd0;
            end else begin
                alu_d  = alu_data_in;
                rt_d   = rt_in;
                pc_d   = pc_in;
                ctrl_d = control_in[7:1];
                rd_d   = regdst_in;
                vec_d  = vector_in;
            end
        end
    end

    always_comb begin
        wb_data_d     = 32'd0;
        wb_regdst_d   = 5'd0;
        wb_regwrite_d = 1'b0;
        wb_vector_d   = 5'd0;
        wb_pc_d       = 32'd0;
        if (!stall) begin
            wb_data_d     = ctrl_q[3] ? w_load : alu_q;
            wb_regdst_d   = rd_q;
            wb_regwrite_d = w_eff_rw;
            wb_vector_d   = w_eff_vec;
            wb_pc_d       = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ldbuf_q       <= 32'd0;
            alu_q         <= 32'd0;
            rt_q          <= 32'd0;
            pc_q          <= 32'd0;
            ctrl_q        <= 7'd0;
            rd_q          <= 5'd0;
            vec_q         <= 5'd0;
            wb_data_q     <= 32'd0;
            wb_regdst_q   <= 5'd0;
            wb_regwrite_q <= 1'b0;
            wb_vector_q   <= 5'd0;
            wb_pc_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            ldbuf_q       <= ldbuf_d;
            alu_q         <= alu_d;
            rt_q          <= rt_d;
            pc_q          <= pc_d;
            ctrl_q        <= ctrl_d;
            rd_q          <= rd_d;
            vec_q         <= vec_d;
            wb_data_q     <= wb_data_d;
            wb_regdst_q   <= wb_regdst_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_vector_q   <= wb_vector_d;
            wb_pc_q       <= wb_pc_d;
        end
    end

    assign ex_mem_data     = alu_q;
    assign ex_mem_regdst   = rd_q;
    assign ex_mem_regwrite = w_eff_rw;
    assign wb_data         = wb_data_q;
    assign wb_regdst       = wb_regdst_q;
    assign wb_regwrite     = wb_regwrite_q;
    assign wb_vector       = wb_vector_q;
    assign wb_pc           = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage : randomized bench for mem_stage with an instruction model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

    localparam logic [4:0] VL = 5'd4;
    localparam logic [4:0] VS = 5'd5;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        logic [4:0]  vin;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          w;
        logic [31:0] rdata;
        int          lit_stall;
        logic        chk_data;
        logic [31:0] lit_data;
        logic [4:0]  lit_vec;
        logic        lit_rw;
        logic        chk_st;
        logic [3:0]  lit_be;
        logic [31:0] lit_wdata;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_data_in, rt_in, pc_in, dmem_rdata;
    logic [7:0]  control_in;
    logic [4:0]  regdst_in, vector_in;
    logic        flush, dmem_ack;
    logic        dmem_req, dmem_we, stall, ex_mem_regwrite, wb_regwrite;
    logic [31:0] dmem_addr, dmem_wdata, ex_mem_data, wb_data, wb_pc;
    logic [3:0]  dmem_be;
    logic [4:0]  ex_mem_regdst, wb_regdst, wb_vector;

    always #5 clk = ~clk;

    mem_stage #(.VEC_LOAD_MISALIGN(VL), .VEC_STORE_MISALIGN(VS)) dut (
        .clk(clk), .rst_n(rst_n), .alu_data_in(alu_data_in), .rt_in(rt_in),
        .control_in(control_in), .regdst_in(regdst_in), .vector_in(vector_in),
        .pc_in(pc_in), .flush(flush), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall(stall),
        .ex_mem_data(ex_mem_data), .ex_mem_regdst(ex_mem_regdst),
        .ex_mem_regwrite(ex_mem_regwrite), .wb_data(wb_data), .wb_regdst(wb_regdst),
        .wb_regwrite(wb_regwrite), .wb_vector(wb_vector), .wb_pc(wb_pc)
    );

    int checks = 0;
    int errors = 0;
    dir_t dq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   32'(dmem_req), 32'd0);
        chk({tag, "_we"},    32'(dmem_we), 32'd0);
        chk({tag, "_addr"},  dmem_addr, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_be"},    32'(dmem_be), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_exd"},   ex_mem_data, 32'd0);
        chk({tag, "_exrd"},  32'(ex_mem_regdst), 32'd0);
        chk({tag, "_exrw"},  32'(ex_mem_regwrite), 32'd0);
        chk({tag, "_wbd"},   wb_data, 32'd0);
        chk({tag, "_wbrd"},  32'(wb_regdst), 32'd0);
        chk({tag, "_wbrw"},  32'(wb_regwrite), 32'd0);
        chk({tag, "_wbvec"}, 32'(wb_vector), 32'd0);
        chk({tag, "_wbpc"},  wb_pc, 32'd0);
    endtask

    // Access width in bytes and the lowest byte lane it touches.
    function automatic int nbytes(input logic [7:0] c);
        if (c[5:4] == 2'd1) return 2;
        if (c[5:4] == 2'd2) return 1;
        return 4;
    endfunction

    function automatic int lane_off(input instr_t i);
        int n = nbytes(i.ctrl);
        return (int'(i.alu[1:0]) / n) * n;
    endfunction

    function automatic logic [4:0] m_vec(input instr_t i);
        int  n   = nbytes(i.ctrl);
        bit  mis = (i.alu % 32'(n)) != 0;
        if (i.vin != 5'd0) return i.vin;
        if (mis && i.ctrl[7]) return VL;
        if (mis && i.ctrl[6]) return VS;
        return 5'd0;
    endfunction

    function automatic bit m_memop(input instr_t i);
        return (i.ctrl[7] || i.ctrl[6]) && m_vec(i) == 5'd0;
    endfunction

    function automatic bit m_rw(input instr_t i);
        return i.ctrl[2] && m_vec(i) == 5'd0;
    endfunction

    function automatic logic [3:0] m_be(input instr_t i);
        logic [3:0] be;
        int n = nbytes(i.ctrl);
        int o = lane_off(i);
        for (int l = 0; l < 4; l++) be[l] = (l >= o) && (l < o + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input instr_t i);
        logic [31:0] wd;
        int n = nbytes(i.ctrl);
        for (int l = 0; l < 4; l++) wd[8*l +: 8] = i.rt[8*(l % n) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input instr_t i, input logic [31:0] b);
        int n = nbytes(i.ctrl);
        logic [31:0] v = b >> (8 * lane_off(i));
        logic [31:0] mask;
        if (n == 4) return v;
        mask = (n == 2) ? 32'h0000FFFF : 32'h000000FF;
        v = v & mask;
        if (!i.ctrl[1] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i.alu  = $urandom;
        if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
        i.rt   = $urandom;
        i.pc   = $urandom & 32'hFFFFFFFC;
        i.ctrl = 8'($urandom);
        if (i.ctrl[5:4] == 2'd3) i.ctrl[5:4] = 2'd0;
        i.rd   = 5'($urandom);
        i.vin  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic fl);
        alu_data_in = i.alu;
        rt_in       = i.rt;
        pc_in       = i.pc;
        control_in  = i.ctrl;
        regdst_in   = i.rd;
        vector_in   = i.vin;
        flush       = fl;
    endtask

    task automatic add_dir(input logic [31:0] alu, input logic [31:0] rt, input logic [7:0] ctrl,
                           input logic [4:0] rd, input logic [4:0] vin, input int w,
                           input logic [31:0] rdata, input int lstall, input logic cdata,
                           input logic [31:0] ldata, input logic [4:0] lvec, input logic lrw,
                           input logic cst, input logic [3:0] lbe, input logic [31:0] lwd);
        dir_t d;
        d.ins.alu = alu; d.ins.rt = rt; d.ins.ctrl = ctrl; d.ins.rd = rd; d.ins.vin = vin;
        d.ins.pc  = 32'h1000 + 32'(dq.size() * 4);
        d.w = w; d.rdata = rdata; d.lit_stall = lstall; d.chk_data = cdata;
        d.lit_data = ldata; d.lit_vec = lvec; d.lit_rw = lrw;
        d.chk_st = cst; d.lit_be = lbe; d.lit_wdata = lwd;
        dq.push_back(d);
    endtask

    instr_t      cur, nx;
    int          k, w, dstall;
    logic [31:0] lbuf, ackd, e_data, e_pc;
    logic [4:0]  e_rd, e_vec;
    logic        e_rw, e_bub, nfl, mo, st_e, rq_e;
    bit          cur_dir, lit_pend;
    dir_t        cur_d, lit_d;

    initial begin
        rst_n = 1'b0;
        drive('0, 1'b0);
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        add_dir(32'h1234, 32'h0, 8'h04, 5'd5, 5'd0, 0, 32'h0, 0, 1'b1, 32'h1234, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0);
        add_dir(32'h100, 32'h0, 8'h8C, 5'd3, 5'd0, 0, 32'hDEADBEEF, 2, 1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0);
        add_dir(32'h103, 32'h0, 8'hAC, 5'd6, 5'd0, 1, 32'h80FF0011, 3, 1'b1, 32'hFFFFFF80, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0);
        add_dir(32'h103, 32'h0, 8'hAE, 5'd7, 5'd0, 0, 32'h80FF0011, 2, 1'b1, 32'h00000080, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0);
        add_dir(32'h22, 32'h0000ABCD, 8'h50, 5'd9, 5'd0, 3, 32'h0, 5, 1'b1, 32'h22, 5'd0, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD);
        add_dir(32'h101, 32'h0, 8'h8C, 5'd4, 5'd0, 0, 32'h0, 0, 1'b0, 32'h0, 5'd4, 1'b0, 1'b0, 4'h0, 32'h0);
        add_dir(32'h101, 32'h0, 8'h8C, 5'd4, 5'd7, 0, 32'h0, 0, 1'b0, 32'h0, 5'd7, 1'b0, 1'b0, 4'h0, 32'h0);

        cur = '0; k = 0; w = 0; dstall = 0; lbuf = 32'd0;
        e_data = 32'd0; e_pc = 32'd0; e_rd = 5'd0; e_vec = 5'd0; e_rw = 1'b0; e_bub = 1'b0;
        cur_dir = 1'b0; lit_pend = 1'b0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            mo   = m_memop(cur);
            st_e = mo && (k <= 1 + w);
            rq_e = mo && (k >= 1) && (k <= 1 + w);
            chk("stall", 32'(stall), 32'(st_e));
            chk("dmem_req", 32'(dmem_req), 32'(rq_e));
            chk("dmem_we", 32'(dmem_we), 32'(rq_e & cur.ctrl[6]));
            chk("dmem_addr", dmem_addr, rq_e ? {cur.alu[31:2], 2'b00} : 32'd0);
            if (rq_e && cur.ctrl[6]) begin
                chk("dmem_be", 32'(dmem_be), 32'(m_be(cur)));
                chk("dmem_wdata", dmem_wdata, m_wdata(cur));
            end else if (!rq_e) begin
                chk("dmem_be_idle", 32'(dmem_be), 32'd0);
                chk("dmem_wdata_idle", dmem_wdata, 32'd0);
            end
            chk("ex_mem_data", ex_mem_data, cur.alu);
            chk("ex_mem_regdst", 32'(ex_mem_regdst), 32'(cur.rd));
            chk("ex_mem_regwrite", 32'(ex_mem_regwrite), 32'(m_rw(cur)));
            chk("wb_regwrite", 32'(wb_regwrite), 32'(e_rw));
            chk("wb_vector", 32'(wb_vector), 32'(e_vec));
            if (!e_bub) begin
                chk("wb_data", wb_data, e_data);
                chk("wb_regdst", 32'(wb_regdst), 32'(e_rd));
                chk("wb_pc", wb_pc, e_pc);
            end
            if (lit_pend) begin
                if (lit_d.chk_data) chk("lit_wb_data", wb_data, lit_d.lit_data);
                chk("lit_wb_vector", 32'(wb_vector), 32'(lit_d.lit_vec));
                chk("lit_wb_regwrite", 32'(wb_regwrite), 32'(lit_d.lit_rw));
                lit_pend = 1'b0;
            end
            if (cur_dir) begin
                if (stall) dstall++;
                if (rq_e && cur_d.chk_st) begin
                    chk("lit_be", 32'(dmem_be), 32'(cur_d.lit_be));
                    chk("lit_wdata", dmem_wdata, cur_d.lit_wdata);
                    chk("lit_we", 32'(dmem_we), 32'd1);
                end
            end

            dmem_ack = mo && (k == 1 + w);
            if (dmem_ack) begin
                ackd = cur_dir ? cur_d.rdata : $urandom;
                lbuf = ackd;
                dmem_rdata = ackd;
            end else begin
                dmem_rdata = $urandom;
            end

            if (st_e) begin
                e_bub = 1'b1; e_rw = 1'b0; e_vec = 5'd0;
                k++;
                drive(rnd_instr(), 1'($urandom_range(0, 1)));
            end else begin
                e_bub  = 1'b0;
                e_data = cur.ctrl[3] ? m_load(cur, lbuf) : cur.alu;
                e_rd   = cur.rd;
                e_rw   = m_rw(cur);
                e_vec  = m_vec(cur);
                e_pc   = cur.pc;
                if (cur_dir) begin
                    chk("lit_stall_cycles", 32'(dstall), 32'(cur_d.lit_stall));
                    lit_pend = 1'b1;
                    lit_d = cur_d;
                end
                if (dq.size() > 0) begin
                    cur_d = dq.pop_front();
                    cur_dir = 1'b1;
                    nx = cur_d.ins; nfl = 1'b0; w = cur_d.w;
                end else begin
                    cur_dir = 1'b0;
                    nx = rnd_instr();
                    nfl = ($urandom_range(0, 7) == 0);
                    w = $urandom_range(0, 3);
                end
                drive(nx, nfl);
                cur = nfl ? '0 : nx;
                k = 0;
                dstall = 0;
            end
        end

        // Reset while a request is outstanding, then a stray acknowledge.
        @(negedge clk);
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        drive('0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nx = '0;
        nx.alu = 32'h200; nx.ctrl = 8'h8C; nx.rd = 5'd2;
        drive(nx, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_pre_req", 32'(dmem_req), 32'd1);
        chk("rst_pre_stall", 32'(stall), 32'd1);
        #1 rst_n = 1'b0;
        drive('0, 1'b0);
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stray_stall", 32'(stall), 32'd0);
            chk("stray_req", 32'(dmem_req), 32'd0);
            chk("stray_we", 32'(dmem_we), 32'd0);
            chk("stray_wbrw", 32'(wb_regwrite), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
